coeff_buf_pp_ctrl: RTL and testbench
====================================

Name: coeff_buf_pp_ctrl

Overview:
Ping-pong controller for the 512-entry dual-port coefficient buffer (128-bit rows, port A byte-half write enables, port B read). It splits the RAM into two 256-row banks. The transform/quant writer fills one bank through port A while the entropy-coder reader drains the other through port B. It also tracks per-bank state and length, and flags protocol errors.

Parameters:
DATA_W, `COEFF_WIDTH*8 (128), row width of the buffer
BANK_AW, 8, row address width inside one bank (256 rows per bank)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
clr  input  1  synchronous flush; same effect as rst
wr_ready  output  1  current write bank accepts beats
wr_val  input  1  write beat valid
wr_we  input  2  half-select code passed to RAM a_we (00 full, 01 low-half swapped, 10 high-half; 11 illegal)
wr_data  input  DATA_W  write row
wr_last  input  1  final beat of block; closes bank
rd_avail  output  1  a filled bank is readable
rd_len  output  BANK_AW+1  row count of the readable bank (1..256)
rd_req  input  1  read-beat request
rd_val  output  1  read data valid
rd_data  output  DATA_W  read row
rd_last  output  1  with rd_val, last row of the bank
err_ovf  output  1  sticky: beat 256 accepted without wr_last
err_drop  output  1  sticky: wr_val while wr_ready low
a_ce  output  1  RAM port A enable
a_we  output  2  RAM port A write code
a_addr  output  9  RAM port A address
a_data_i  output  DATA_W  RAM port A write data
b_ce  output  1  RAM port B enable
b_we  output  2  RAM port B code, tied 2'b11
b_addr  output  9  RAM port B address
b_data_i  output  DATA_W  tied 0
b_data_o  input  DATA_W  RAM port B read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset/clr:
  - Both banks EMPTY; wsel=0, rsel=0; wr_cnt=0, rd_cnt=0, len[0..1]=0.
  - Outputs: wr_ready=1, rd_avail=0, rd_len=0, rd_val=0, rd_last=0, err flags 0, a_ce=0, a_we=2'b11, b_ce=0.
  - Mid-operation reset or clr discards in-flight beats, and no rd_val follows.
- Bank state per bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Write side:
  - wr_ready = bank[wsel] in {EMPTY, FILLING}.
  - Accepted beat: wr_val && wr_ready. It drives a_ce=1, a_we=wr_we, a_addr={wsel,wr_cnt[7:0]}, a_data_i=wr_data, all combinationally in the same cycle. wr_cnt then increments.
  - The first accepted beat moves an EMPTY bank to FILLING.
  - Accepted beat with wr_last, or with wr_cnt==255: bank goes FULL, len[wsel]=wr_cnt+1, wsel toggles, wr_cnt=0. If wr_last is low in that wr_cnt==255 case, err_ovf is set.
  - wr_val && !wr_ready: beat dropped, a_ce=0, err_drop set.
  - Non-accepted cycles: a_ce=0, a_we=2'b11.
- Read side:
  - rd_avail = bank[rsel] in {FULL, DRAINING}.
  - rd_len = len[rsel] when rd_avail, else 0.
  - Issued beat: rd_req && rd_avail. It drives b_ce=1, b_addr={rsel,rd_cnt[7:0]} combinationally; rd_cnt then increments.
  - The first issued beat moves FULL to DRAINING.
  - Issue of the beat with rd_cnt==len[rsel]-1: bank goes EMPTY, rsel toggles, rd_cnt=0.
  - rd_req without rd_avail is ignored.
- Read latency: fixed 1 cycle. rd_val and rd_last are registered from the issue cycle; rd_data = b_data_o when rd_val, else 0.
- The reader must accept every rd_val; there is no backpressure beyond withholding rd_req.
- Hazard: a bank freed at last-read issue may be written from the next cycle. The RAM read occurs on the issue edge, so there is no read/write collision.
- Simultaneous events in one cycle are legal and independent on opposite banks: write close plus read close, or write beat plus read beat.
- A bank closed by a write becomes readable (rd_avail) the next cycle.

Test Plan:
- Reset, then 4 full-row beats with wr_we=00 and last on beat 4 -> a_addr 0..3, a_we=00. Bank0 FULL, next-cycle rd_avail=1, rd_len=4, wr_ready=1 (bank1).
- 4 rd_req cycles after scenario 1 -> b_addr 0..3. rd_val one cycle later with data matching written rows; rd_last on 4th. Bank0 EMPTY, rd_avail=0.
- Fill bank0 (8 rows) and bank1 (8 rows) with no reads -> wr_ready=0. One extra wr_val -> err_drop=1, a_ce=0. Then drain bank0 -> wr_ready=1, next write goes to a_addr=0.
- 256 beats without wr_last -> err_ovf=1, len=256, rd_len=256. Reader drains rows 0..255 with rd_last on row 255.
- Concurrent: write bank1 (a_addr 256..) while reading bank0 each cycle -> both ports active every cycle, data intact, rsel/wsel toggle independently.
- Assert clr mid-fill and mid-drain -> next cycle all banks EMPTY, rd_val=0, flags cleared, a_we=2'b11.

Source files
------------

// File: rtl/coeff_buf_pp_ctrl.sv
// Ping-pong controller for the 512-row coefficient buffer: the writer fills one 256-row bank on port A
// while the reader drains the other bank on port B, with per-bank state, length and sticky error flags.
module coeff_buf_pp_ctrl #(
    parameter int DATA_W  = 128,
    parameter int BANK_AW = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                wr_ready,
    input  logic                wr_val,
    input  logic [1:0]          wr_we,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_last,
    output logic                rd_avail,
    output logic [BANK_AW:0]    rd_len,
    input  logic                rd_req,
    output logic                rd_val,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                err_ovf,
    output logic                err_drop,
    output logic                a_ce,
    output logic [1:0]          a_we,
    output logic [BANK_AW:0]    a_addr,
    output logic [DATA_W-1:0]   a_data_i,
    output logic                b_ce,
    output logic [1:0]          b_we,
    output logic [BANK_AW:0]    b_addr,
    output logic [DATA_W-1:0]   b_data_i,
    input  logic [DATA_W-1:0]   b_data_o
);

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_FILLING  = 2'd1,
        ST_FULL     = 2'd2,
        ST_DRAINING = 2'd3
    } bank_st_e;

    localparam logic [BANK_AW-1:0] CNT_ONE = BANK_AW'(1);
    localparam logic [BANK_AW:0]   LEN_ONE = (BANK_AW + 1)'(1);

    bank_st_e           st_q   [2];
    bank_st_e           st_d   [2];
    logic [BANK_AW:0]   len_q  [2];
    logic [BANK_AW:0]   len_d  [2];
    logic               wsel_q, wsel_d;
    logic               rsel_q, rsel_d;
    logic [BANK_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [BANK_AW-1:0] rd_cnt_q, rd_cnt_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_drop_q, err_drop_d;
    logic               rd_val_q, rd_val_d;
    logic               rd_last_q, rd_last_d;

    logic flush;
    logic wr_accept, wr_close;
    logic rd_issue, rd_close;

    // A flush cycle suppresses both RAM ports so no beat of the discarded state reaches the buffer.
    assign flush     = rst | clr;
    assign wr_ready  = (st_q[wsel_q] == ST_EMPTY) || (st_q[wsel_q] == ST_FILLING);
    assign rd_avail  = (st_q[rsel_q] == ST_FULL)  || (st_q[rsel_q] == ST_DRAINING);
    assign rd_len    = rd_avail ? len_q[rsel_q] : '0;

    assign wr_accept = wr_val & wr_ready & ~flush;
    assign wr_close  = wr_accept & (wr_last | (wr_cnt_q == '1));
    assign rd_issue  = rd_req & rd_avail & ~flush;
    assign rd_close  = rd_issue & ({1'b0, rd_cnt_q} == (len_q[rsel_q] - LEN_ONE));

    always_comb begin
        st_d[0]    = st_q[0];
        st_d[1]    = st_q[1];
        len_d[0]   = len_q[0];
        len_d[1]   = len_q[1];
        wsel_d     = wsel_q;
        rsel_d     = rsel_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        err_ovf_d  = err_ovf_q;
        err_drop_d = err_drop_q;
        rd_val_d   = rd_issue;
        rd_last_d  = rd_close;

        if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
            if (st_q[wsel_q] == ST_EMPTY) begin
                st_d[wsel_q] = ST_FILLING;
            end
            if (wr_close) begin
                st_d[wsel_q]  = ST_FULL;
                len_d[wsel_q] = {1'b0, wr_cnt_q} + LEN_ONE;
                wsel_d        = ~wsel_q;
                wr_cnt_d      = '0;
                if (!wr_last) begin
                    err_ovf_d = 1'b1;
                end
            end
        end

        if (wr_val && !wr_ready) begin
            err_drop_d = 1'b1;
        end

        // Reads only ever touch the bank opposite the one being written, so both updates compose.
        if (rd_issue) begin
            rd_cnt_d = rd_cnt_q + CNT_ONE;
            if (st_q[rsel_q] == ST_FULL) begin
                st_d[rsel_q] = ST_DRAINING;
            end
            if (rd_close) begin
                st_d[rsel_q] = ST_EMPTY;
                rsel_d       = ~rsel_q;
                rd_cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            st_q[0]    <= ST_EMPTY;
            st_q[1]    <= ST_EMPTY;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wsel_q     <= 1'b0;
            rsel_q     <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            err_ovf_q  <= 1'b0;
            err_drop_q <= 1'b0;
            rd_val_q   <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            st_q[0]    <= st_d[0];
            st_q[1]    <= st_d[1];
            len_q[0]   <= len_d[0];
            len_q[1]   <= len_d[1];
            wsel_q     <= wsel_d;
            rsel_q     <= rsel_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            err_ovf_q  <= err_ovf_d;
            err_drop_q <= err_drop_d;
            rd_val_q   <= rd_val_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign err_ovf  = err_ovf_q;
    assign err_drop = err_drop_q;

    // Port A mirrors the accepted beat in the same cycle; the RAM captures it on the next edge.
    assign a_ce     = wr_accept;
    assign a_we     = wr_accept ? wr_we : 2'b11;
    assign a_addr   = {wsel_q, wr_cnt_q};
    assign a_data_i = wr_data;

    assign b_ce     = rd_issue;
    assign b_we     = 2'b11;
    assign b_addr   = {rsel_q, rd_cnt_q};
    assign b_data_i = '0;

    assign rd_val   = rd_val_q;
    assign rd_last  = rd_last_q;
    assign rd_data  = rd_val_q ? b_data_o : '0;

endmodule

// File: tb/tb_coeff_buf_pp_ctrl.sv
// Randomized scoreboard bench for coeff_buf_pp_ctrl with a block-queue reference model and a RAM stand-in.
module tb_coeff_buf_pp_ctrl;

    logic         clk = 1'b0;
    logic         rst, clr;
    logic         wr_ready, wr_val, wr_last;
    logic [1:0]   wr_we;
    logic [127:0] wr_data;
    logic         rd_avail, rd_req, rd_val, rd_last;
    logic [8:0]   rd_len;
    logic [127:0] rd_data;
    logic         err_ovf, err_drop;
    logic         a_ce, b_ce;
    logic [1:0]   a_we, b_we;
    logic [8:0]   a_addr, b_addr;
    logic [127:0] a_data_i, b_data_i;
    logic [127:0] b_data_o = '0;

    coeff_buf_pp_ctrl #(.DATA_W(128), .BANK_AW(8)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_ready(wr_ready), .wr_val(wr_val), .wr_we(wr_we), .wr_data(wr_data), .wr_last(wr_last),
        .rd_avail(rd_avail), .rd_len(rd_len), .rd_req(rd_req), .rd_val(rd_val),
        .rd_data(rd_data), .rd_last(rd_last), .err_ovf(err_ovf), .err_drop(err_drop),
        .a_ce(a_ce), .a_we(a_we), .a_addr(a_addr), .a_data_i(a_data_i),
        .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_data_i(b_data_i), .b_data_o(b_data_o)
    );

    always #5 clk = ~clk;

    // RAM stand-in: whole-row store for any legal write code, synchronous port-B read.
    logic [127:0] mem [512];
    always @(posedge clk) begin
        if (a_ce && a_we != 2'b11) mem[a_addr] <= a_data_i;
        if (b_ce) b_data_o <= mem[b_addr];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: closed blocks are a queue of lengths plus a flat queue of their rows.
    int           m_lens [$];
    logic [127:0] m_rows [$];
    logic [127:0] m_pend [$];
    int           m_wcnt, m_rdidx, m_nclosed, m_ndrained;
    bit           m_ovf, m_drop;

    typedef struct packed { logic [127:0] d; logic l; } sb_t;
    sb_t exp_q [$];

    task automatic model_reset();
        m_lens.delete(); m_rows.delete(); m_pend.delete();
        m_wcnt = 0; m_rdidx = 0; m_nclosed = 0; m_ndrained = 0;
        m_ovf = 0; m_drop = 0;
    endtask

    task automatic step(input bit wv, input bit wl, input logic [1:0] we, input bit rq, input bit c);
        logic [127:0] d;
        bit           ready, avail, acc, iss;
        logic [8:0]   len_e;
        sb_t          e;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        wr_val = wv; wr_last = wl; wr_we = we; wr_data = d; rd_req = rq; clr = c;
        @(negedge clk);
        ready = (m_lens.size() < 2);
        avail = (m_lens.size() > 0);
        len_e = avail ? 9'(m_lens[0]) : 9'd0;
        chk("wr_ready", wr_ready, ready);
        chk("rd_avail", rd_avail, avail);
        chk("rd_len", rd_len, len_e);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_drop", err_drop, m_drop);
        acc = wv && ready && !c;
        iss = rq && avail && !c;
        if (!c) begin
            chk("a_ce", a_ce, acc);
            chk("b_ce", b_ce, iss);
            if (acc) begin
                chk("a_addr", a_addr, {m_nclosed[0], m_wcnt[7:0]});
                chk("a_we", a_we, we);
                chk("a_data_i", a_data_i, d);
            end else begin
                chk("a_we_idle", a_we, 2'b11);
            end
            if (iss) chk("b_addr", b_addr, {m_ndrained[0], m_rdidx[7:0]});
        end
        if (c) begin
            model_reset();
        end else begin
            if (iss) begin
                e.d = m_rows.pop_front();
                e.l = (m_rdidx == m_lens[0] - 1);
                exp_q.push_back(e);
                m_rdidx++;
                if (e.l) begin
                    void'(m_lens.pop_front());
                    m_rdidx = 0;
                    m_ndrained++;
                end
            end
            if (wv && !ready) m_drop = 1;
            if (acc) begin
                m_pend.push_back(d);
                m_wcnt++;
                if (wl || m_wcnt == 256) begin
                    if (!wl) m_ovf = 1;
                    m_lens.push_back(m_wcnt);
                    foreach (m_pend[i]) m_rows.push_back(m_pend[i]);
                    m_pend.delete();
                    m_wcnt = 0;
                    m_nclosed++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every read beat the DUT presents is matched against the oldest expected row.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (rd_val) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_val: got unexpected beat %h, expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", rd_data, e.d);
                    chk("rd_last", rd_last, e.l);
                end
            end else if (!rst) begin
                chk("rd_data_idle", rd_data, '0);
                chk("rd_last_idle", rd_last, 1'b0);
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wr_val = 1'b0; wr_last = 1'b0; wr_we = 2'b00;
        wr_data = '0; rd_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_rd_avail", rd_avail, 1'b0);
        chk("rst_rd_len", rd_len, 9'd0);
        chk("rst_rd_val", rd_val, 1'b0);
        chk("rst_rd_last", rd_last, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_drop", err_drop, 1'b0);
        chk("rst_a_ce", a_ce, 1'b0);
        chk("rst_a_we", a_we, 2'b11);
        chk("rst_b_ce", b_ce, 1'b0);
        chk("rst_b_we", b_we, 2'b11);
        chk("rst_b_data_i", b_data_i, '0);
        @(posedge clk);
        #1;

        // Four-row block, then read it back.
        for (int i = 0; i < 4; i++) step(1'b1, i == 3, 2'b00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Both banks full, one dropped beat, drain one bank, write again.
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 8; i++) step(1'b1, i == 7, 2'(i % 3), 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);

        // Flush mid-fill (one bank full, other filling).
        step(1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("clr_fill_sb", exp_q.size(), 0);

        // 256 beats without last: overflow closes the bank at full length.
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Random concurrent traffic on both ports.
        for (int i = 0; i < 1500; i++)
            step(($urandom() % 4) != 0, ($urandom() % 16) == 0, 2'($urandom() % 3),
                 ($urandom() % 3) != 0, 1'b0);

        // Flush mid-drain.
        repeat (2) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, i == 7, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
        step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("clr_drain_sb", exp_q.size(), 0);

        // Short random burst, then drain whatever is left.
        for (int i = 0; i < 200; i++)
            step(($urandom() % 2) != 0, ($urandom() % 8) == 0, 2'b00, ($urandom() % 2) != 0, 1'b0);
        for (int i = 0; i < 600 && m_lens.size() > 0; i++) step(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk("final_blocks", m_lens.size(), 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
